pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/load_use_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    StRun    = 1'b0,
    StMcBusy = 1'b1
  } ctrl_state_t;

  // Per-stage-register control: keep contents, or load a nop.
  typedef struct packed {
    logic hold;
    logic bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect #(
  parameter int unsigned REG_COUNT = 32
) (
  input  logic [$clog2(REG_COUNT)-1:0] rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] rs2_addr,
  input  logic                         uses_rs1,
  input  logic                         uses_rs2,
  input  logic                         mem_read,
  input  logic [$clog2(REG_COUNT)-1:0] rd_addr,
  output logic                         hazard
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign rd_nonzero = |rd_addr;
  assign rs1_hit    = uses_rs1 & (rs1_addr == rd_addr);
  assign rs2_hit    = uses_rs2 & (rs2_addr == rd_addr);
  assign hazard     = mem_read & rd_nonzero & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline, with a multi-cycle
// EX handshake, data-memory freeze, MC timeout detection and hazard counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(REG_COUNT)-1:0] id_rs1_addr,
  input  logic [$clog2(REG_COUNT)-1:0] id_rs2_addr,
  input  logic                         id_uses_rs1,
  input  logic                         id_uses_rs2,
  input  logic                         ex_mem_read,
  input  logic [$clog2(REG_COUNT)-1:0] ex_rd_addr,
  input  logic                         ex_branch_taken,
  input  logic                         ex_mc_op,
  input  logic                         mc_done,
  input  logic                         mem_req,
  input  logic                         mem_ready,
  output logic                         pc_hold,
  output logic                         pc_redirect,
  output logic                         if_id_hold,
  output logic                         if_id_flush,
  output logic                         id_ex_hold,
  output logic                         id_ex_bubble,
  output logic                         ex_mem_hold,
  output logic                         ex_mem_bubble,
  output logic                         mem_wb_bubble,
  output logic                         mc_start,
  output logic                         mc_error,
  output logic [CNT_WIDTH-1:0]         stall_cnt,
  output logic [CNT_WIDTH-1:0]         flush_cnt
);

  localparam int unsigned TW = $clog2(MC_TIMEOUT + 1);

  ctrl_state_t    state_q, state_d;
  logic           done_pend_q, done_pend_d;
  logic [TW-1:0]  to_cnt_q;
  logic           mc_error_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  logic        freeze;
  logic        load_use;
  stage_ctrl_t if_id_ctrl;
  stage_ctrl_t id_ex_ctrl;
  stage_ctrl_t ex_mem_ctrl;

  load_use_detect #(
    .REG_COUNT (REG_COUNT)
  ) u_load_use_detect (
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .mem_read (ex_mem_read),
    .rd_addr  (ex_rd_addr),
    .hazard   (load_use)
  );

  assign freeze = mem_req & ~mem_ready;

  always_comb begin
    state_d       = state_q;
    done_pend_d   = done_pend_q;
    pc_hold       = 1'b0;
    pc_redirect   = 1'b0;
    mc_start      = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_ctrl    = '0;
    id_ex_ctrl    = '0;
    ex_mem_ctrl   = '0;

    unique case (state_q)
      StRun: begin
        if (!freeze) begin
          if (ex_branch_taken) begin
            pc_redirect       = 1'b1;
            if_id_ctrl.bubble = 1'b1;
            id_ex_ctrl.bubble = 1'b1;
          end else if (ex_mc_op) begin
            mc_start           = 1'b1;
            pc_hold            = 1'b1;
            if_id_ctrl.hold    = 1'b1;
            id_ex_ctrl.hold    = 1'b1;
            ex_mem_ctrl.bubble = 1'b1;
            state_d            = StMcBusy;
          end else if (load_use) begin
            pc_hold           = 1'b1;
            if_id_ctrl.hold   = 1'b1;
            id_ex_ctrl.bubble = 1'b1;
          end
        end
      end
      StMcBusy: begin
        pc_hold         = 1'b1;
        if_id_ctrl.hold = 1'b1;
        id_ex_ctrl.hold = 1'b1;
        if (!freeze) begin
          // Exit cycle: EX/MEM neither held nor bubbled, so it captures the result.
          if (mc_done || done_pend_q) begin
            state_d     = StRun;
            done_pend_d = 1'b0;
          end else begin
            ex_mem_ctrl.bubble = 1'b1;
          end
        end else if (mc_done) begin
          done_pend_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    // Memory wait overrides everything above.
    if (freeze) begin
      pc_hold          = 1'b1;
      if_id_ctrl.hold  = 1'b1;
      id_ex_ctrl.hold  = 1'b1;
      ex_mem_ctrl.hold = 1'b1;
      mem_wb_bubble    = 1'b1;
    end
  end

  assign if_id_hold    = if_id_ctrl.hold;
  assign if_id_flush   = if_id_ctrl.bubble;
  assign id_ex_hold    = id_ex_ctrl.hold;
  assign id_ex_bubble  = id_ex_ctrl.bubble;
  assign ex_mem_hold   = ex_mem_ctrl.hold;
  assign ex_mem_bubble = ex_mem_ctrl.bubble;
  assign mc_error      = mc_error_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      done_pend_q <= 1'b0;
      to_cnt_q    <= '0;
      mc_error_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      done_pend_q <= done_pend_d;
      if (state_q == StMcBusy) begin
        // Saturate so a long wait never wraps back below the limit.
        if (to_cnt_q != TW'(MC_TIMEOUT)) begin
          to_cnt_q <= to_cnt_q + TW'(1);
        end
        if (to_cnt_q == TW'(MC_TIMEOUT - 1)) begin
          mc_error_q <= 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
      if (pc_hold) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (pc_redirect) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, branch, MC handshake,
// memory freeze with pending done, timeout and async reset.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 5;

  // Output vector bit order: ph pr ih if eh eb mh mb wb ms me
  localparam logic [10:0] ONone   = 11'b000_0000_0000;
  localparam logic [10:0] OLdUse  = 11'b101_0010_0000;
  localparam logic [10:0] OBranch = 11'b010_1010_0000;
  localparam logic [10:0] OMcGo   = 11'b101_0100_1010;
  localparam logic [10:0] OMcBusy = 11'b101_0100_1000;
  localparam logic [10:0] OMcDone = 11'b101_0100_0000;
  localparam logic [10:0] OFreeze = 11'b101_0101_0100;
  localparam logic [10:0] OMcErr  = 11'b101_0100_1001;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mc_op;
  logic mc_done, mem_req, mem_ready;
  logic pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble;
  logic ex_mem_hold, ex_mem_bubble, mem_wb_bubble, mc_start, mc_error;
  logic [31:0] stall_cnt, flush_cnt;
  logic [10:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(
    .REG_COUNT  (32),
    .CNT_WIDTH  (32),
    .MC_TIMEOUT (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd_addr      (ex_rd_addr),
    .ex_branch_taken (ex_branch_taken),
    .ex_mc_op        (ex_mc_op),
    .mc_done         (mc_done),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_hold         (pc_hold),
    .pc_redirect     (pc_redirect),
    .if_id_hold      (if_id_hold),
    .if_id_flush     (if_id_flush),
    .id_ex_hold      (id_ex_hold),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .ex_mem_bubble   (ex_mem_bubble),
    .mem_wb_bubble   (mem_wb_bubble),
    .mc_start        (mc_start),
    .mc_error        (mc_error),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_hold, pc_redirect, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
                 ex_mem_hold, ex_mem_bubble, mem_wb_bubble, mc_start, mc_error};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mc_op = 1'b0; mc_done = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance to 1 ns after the next rising edge; inputs are then applied and
  // outputs are sampled 2 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    settle();
    check_eq("reset_outs", 32'(outs), 32'(ONone));
    check_eq("reset_stall", stall_cnt, 32'd0);
    check_eq("reset_flush", flush_cnt, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Load x5 in EX, ID reads rs1=x5.
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    settle();
    check_eq("lu_rs1", 32'(outs), 32'(OLdUse));
    next_cycle();
    clear_inputs();
    settle();
    check_eq("lu_after", 32'(outs), 32'(ONone));
    check_eq("lu_stall_cnt", stall_cnt, 32'd1);

    // Load into x0 never stalls.
    ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1;
    settle();
    check_eq("lu_rd0", 32'(outs), 32'(ONone));

    // rs2 matches but is not read, then is read.
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_rs2_addr = 5'd7;
    settle();
    check_eq("lu_rs2_unused", 32'(outs), 32'(ONone));
    id_uses_rs2 = 1'b1;
    #1;
    check_eq("lu_rs2", 32'(outs), 32'(OLdUse));
    next_cycle();
    clear_inputs();
    settle();
    check_eq("lu_rs2_stall_cnt", stall_cnt, 32'd2);

    // Taken branch together with a load-use condition: branch wins.
    ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    settle();
    check_eq("branch_outs", 32'(outs), 32'(OBranch));
    next_cycle();
    clear_inputs();
    settle();
    check_eq("branch_flush_cnt", flush_cnt, 32'd1);
    check_eq("branch_stall_cnt", stall_cnt, 32'd2);

    // Multi-cycle op, mc_done five cycles after the start; ex_mc_op stays high.
    ex_mc_op = 1'b1;
    settle();
    check_eq("mc_start_cycle", 32'(outs), 32'(OMcGo));
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      settle();
      check_eq($sformatf("mc_busy%0d", i), 32'(outs), 32'(OMcBusy));
    end
    next_cycle();
    mc_done = 1'b1;
    settle();
    check_eq("mc_done_cycle", 32'(outs), 32'(OMcDone));
    next_cycle();
    clear_inputs();
    settle();
    check_eq("mc_back_run", 32'(outs), 32'(ONone));
    check_eq("mc_stall_cnt", stall_cnt, 32'd8);

    // Freeze in RUN masks a branch and an MC op.
    mem_req = 1'b1; ex_branch_taken = 1'b1; ex_mc_op = 1'b1;
    settle();
    check_eq("freeze_run", 32'(outs), 32'(OFreeze));
    next_cycle();
    clear_inputs();
    settle();
    check_eq("freeze_run_after", 32'(outs), 32'(ONone));
    check_eq("freeze_run_flush", flush_cnt, 32'd1);

    // mc_done arrives during a three-cycle memory wait.
    ex_mc_op = 1'b1;
    settle();
    check_eq("pend_start", 32'(outs), 32'(OMcGo));
    next_cycle();
    ex_mc_op = 1'b0;
    settle();
    check_eq("pend_busy", 32'(outs), 32'(OMcBusy));
    next_cycle();
    mc_done = 1'b1; mem_req = 1'b1;
    settle();
    check_eq("pend_freeze0", 32'(outs), 32'(OFreeze));
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      mc_done = 1'b0;
      settle();
      check_eq($sformatf("pend_freeze%0d", i), 32'(outs), 32'(OFreeze));
    end
    next_cycle();
    mem_ready = 1'b1;
    settle();
    check_eq("pend_exit", 32'(outs), 32'(OMcDone));
    next_cycle();
    clear_inputs();
    settle();
    check_eq("pend_run", 32'(outs), 32'(ONone));
    check_eq("pend_stall_cnt", stall_cnt, 32'd15);

    // Timeout: mc_done never arrives.
    ex_mc_op = 1'b1;
    settle();
    check_eq("to_start", 32'(outs), 32'(OMcGo));
    next_cycle();
    clear_inputs();
    for (int i = 1; i <= 8; i++) begin
      settle();
      check_eq($sformatf("to_busy%0d", i), 32'(outs), 32'(OMcBusy));
      next_cycle();
    end
    settle();
    check_eq("to_error", 32'(outs), 32'(OMcErr));
    check_eq("to_stall_cnt", stall_cnt, 32'd24);

    // Asynchronous reset mid-wait.
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_outs", 32'(outs), 32'(ONone));
    check_eq("rst_stall", stall_cnt, 32'd0);
    check_eq("rst_flush", flush_cnt, 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    settle();
    check_eq("rst_run_idle", 32'(outs), 32'(ONone));
    ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs2_addr = 5'd3; id_uses_rs2 = 1'b1;
    #1;
    check_eq("rst_run_lu", 32'(outs), 32'(OLdUse));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
